cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default CDB_REQ_NUM (4): number of functional-unit requesters (0 alu, 1 mul, 2 br, 3 load).
REQ-002 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  NUM_REQ  per-requester result valid.
REQ-005 SHALL have port req_entry  input  NUM_REQ x cdb_entry_t  per-requester result.
REQ-006 SHALL have port req_ready  output  NUM_REQ  slot can accept this cycle.
REQ-007 SHALL have port cdb  output  cdb_entry_t  broadcast to ROB, RS, RAT and physical register file.
REQ-008 SHALL have port flush  input  1  full pipeline flush.
REQ-009 SHALL have port br_resolve_valid  input  1  a control instruction resolved this cycle.
REQ-010 SHALL have port br_resolve_mispredict  input  1  the resolved instruction mispredicted.
REQ-011 SHALL have port br_resolve_bit  input  CONTROL_Q_DEPTH  one-hot control-queue bit of the resolved instruction.

Function
REQ-012 SHALL hold one registered slot (valid + cdb_entry_t) per requester.
REQ-013 SHALL drive req_ready[i] = !slot_valid[i] | grant[i]; a requester may hand over one result per cycle back-to-back.
REQ-014 SHALL capture req_entry[i] into slot i at the edge where req_valid[i] & req_ready[i], unless it is killed (REQ-019, REQ-020).
REQ-015 SHALL compute eligible = slot_valid & ~kill_this_cycle; at most one grant per cycle.
REQ-016 SHALL grant round-robin: winner = first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-017 SHALL set rr_ptr to (winner+1) mod NUM_REQ on a grant and hold it when there is no grant.
REQ-018 SHALL drive cdb combinationally from the winning slot with cdb.valid=1, and cdb.valid=0 when there is no grant; latency is 1 cycle from acceptance edge to broadcast, and the slot clears at the following edge unless refilled.
REQ-019 On br_resolve_valid & br_resolve_mispredict, SHALL kill every slot whose control_bit_map & br_resolve_bit is nonzero: excluded from arbitration that cycle and invalidated at the edge; a matching incoming request SHALL be dropped, with req_ready unaffected.
REQ-020 On flush, SHALL kill all slots and incoming requests, force cdb.valid=0 that cycle, and leave rr_ptr unchanged.
REQ-021 On br_resolve_valid & !br_resolve_mispredict, SHALL clear br_resolve_bit in the control_bit_map of every retained slot and of any entry captured that edge; the broadcast cdb SHALL already show the bit cleared.
REQ-022 SHALL give flush precedence over resolve, and a kill on a slot precedence over its grant.
REQ-023 SHALL pass all cdb_entry_t fields other than valid and control_bit_map unmodified.

Reset
REQ-024 While rst_n=0, SHALL clear all slot_valid, set rr_ptr=0, and hold cdb.valid=0 with req_ready all ones; other cdb fields are don't-care.
REQ-025 Reset mid-operation SHALL discard all slots immediately, with no broadcast in the reset cycle.

Structure
REQ-026 SHALL take CDB_REQ_NUM and CDB_REQ_IDX_BITS=$clog2(CDB_REQ_NUM) from package params; cdb_entry_t and CONTROL_Q_DEPTH stay in rv32i_types/params.
REQ-027 SHALL place the pointer-based pick in one combinational sub-module cdb_rr_pick (inputs eligible, rr_ptr; outputs grant one-hot, grant_valid, winner index).

Verification
REQ-028 Single req: after reset, req_valid=0001 with phys_d_reg=5, rd_v=0x1234 for one cycle -> next cycle cdb.valid=1, phys_d_reg=5, rd_v=0x1234, rr_ptr->1; following cycle cdb.valid=0.
REQ-029 Contention: all four slots filled the same edge with rr_ptr=0 -> cdb shows requesters 0,1,2,3 on four consecutive cycles, and req_ready[i] pulses 1 during each grant cycle.
REQ-030 Fairness: requester 0 held valid continuously, requester 2 valid once -> requester 2 is granted within 2 cycles, with no starvation over 100 cycles of random traffic.
REQ-031 Mispredict: slots 1 (map 0010) and 3 (map 0100) valid, rr_ptr=1, resolve mispredict bit 0010 -> cdb shows slot 3 that cycle and slot 1 is never broadcast.
REQ-032 Correct resolve: slot map 0110, resolve bit 0100 not mispredicted -> broadcast control_bit_map=0010.
REQ-033 Flush and reset: flush with 3 valid slots, then rst_n pulsed low mid-stream -> cdb.valid=0 in the flush cycle and throughout reset, all slots empty, req_ready=1111.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Helpers for the CDB arbiter: control-bit-map hit test and resolve clear.
// No ports.
package cdb_arbiter_pkg;

  import params::*;

  typedef logic [CONTROL_Q_DEPTH-1:0] ctrl_map_t;

  // True when an entry depends on the resolved control instruction.
  function automatic logic ctrl_hit(ctrl_map_t map, ctrl_map_t resolve_bit);
    return |(map & resolve_bit);
  endfunction

  // Drops the resolved dependency when a branch resolves correctly.
  function automatic ctrl_map_t ctrl_clear(ctrl_map_t map, ctrl_map_t resolve_bit,
                                           logic en);
    return en ? (map & ~resolve_bit) : map;
  endfunction

endpackage

// File: rtl/params.sv
// Project-wide sizing constants shared by the out-of-order core.
// No ports; imported by the type package and the CDB logic.
package params;

  localparam int unsigned CONTROL_Q_DEPTH  = 4;
  localparam int unsigned ROB_DEPTH        = 32;
  localparam int unsigned ROB_IDX_BITS     = $clog2(ROB_DEPTH);
  localparam int unsigned PHYS_REG_NUM     = 64;
  localparam int unsigned PHYS_REG_BITS    = $clog2(PHYS_REG_NUM);

  // CDB requesters: 0 alu, 1 mul, 2 br, 3 load
  localparam int unsigned CDB_REQ_NUM      = 4;
  localparam int unsigned CDB_REQ_IDX_BITS = $clog2(CDB_REQ_NUM);

endpackage

// File: rtl/rv32i_types.sv
// Shared datapath types for the out-of-order core.
// No ports; cdb_entry_t is the common data bus payload.
package rv32i_types;

  import params::*;

  typedef struct packed {
    logic                       valid;
    logic [ROB_IDX_BITS-1:0]    rob_idx;
    logic [4:0]                 arch_d_reg;
    logic [PHYS_REG_BITS-1:0]   phys_d_reg;
    logic [31:0]                rd_v;
    // One bit per unresolved control instruction this result depends on
    logic [CONTROL_Q_DEPTH-1:0] control_bit_map;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_rr_pick.sv
// Round-robin picker: first eligible index at or after rr_ptr, wrapping.
// Ports:
//   eligible_i    - requesters that may be granted this cycle
//   rr_ptr_i      - highest-priority index this cycle
//   grant_o       - one-hot grant
//   grant_valid_o - any grant issued
//   winner_o      - binary index of the granted requester
module cdb_rr_pick
  import params::*;
#(
  parameter int unsigned N     = CDB_REQ_NUM,
  parameter int unsigned IDX_W = CDB_REQ_IDX_BITS
) (
  input  logic [N-1:0]     eligible_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [N-1:0]     grant_o,
  output logic             grant_valid_o,
  output logic [IDX_W-1:0] winner_o
);

  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    winner_o      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned      idx;
      logic [IDX_W-1:0] idx_l;
      idx = 32'(rr_ptr_i) + k;
      if (idx >= N) idx = idx - N;
      idx_l = IDX_W'(idx);
      if (!grant_valid_o && eligible_i[idx_l]) begin
        grant_o[idx_l] = 1'b1;
        grant_valid_o  = 1'b1;
        winner_o       = idx_l;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one registered slot per functional unit, a
// round-robin grant of one slot per cycle onto the CDB, and squash/clear of
// buffered results on branch resolution and pipeline flush.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   req_valid/req_entry   - per-requester result handoff
//   req_ready             - slot empty or being broadcast this cycle
//   cdb                   - broadcast to ROB, RS, RAT and PRF
//   flush                 - kill everything buffered and incoming
//   br_resolve_*          - control instruction resolution (one-hot bit)
module cdb_arbiter
  import params::*;
  import rv32i_types::*;
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = CDB_REQ_NUM
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  cdb_entry_t                 req_entry [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_ready,
  output cdb_entry_t                 cdb,
  input  logic                       flush,
  input  logic                       br_resolve_valid,
  input  logic                       br_resolve_mispredict,
  input  logic [CONTROL_Q_DEPTH-1:0] br_resolve_bit
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] slot_valid_q, slot_valid_d;
  cdb_entry_t         slot_q [NUM_REQ];
  cdb_entry_t         slot_d [NUM_REQ];
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               mp_kill;
  logic               resolve_ok;
  logic [NUM_REQ-1:0] slot_kill;
  logic [NUM_REQ-1:0] in_kill;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [IDX_W-1:0]   winner;

  // Flush wins over resolve, so a correct-resolve clear is irrelevant then.
  assign mp_kill    = br_resolve_valid & br_resolve_mispredict;
  assign resolve_ok = br_resolve_valid & ~br_resolve_mispredict & ~flush;

  always_comb begin
    slot_kill = '0;
    in_kill   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slot_kill[i] = flush | (mp_kill & ctrl_hit(slot_q[i].control_bit_map, br_resolve_bit));
      in_kill[i]   = flush | (mp_kill & ctrl_hit(req_entry[i].control_bit_map, br_resolve_bit));
    end
  end

  // A killed slot never reaches the bus, even if it would have won.
  assign eligible = slot_valid_q & ~slot_kill;

  cdb_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .eligible_i    (eligible),
    .rr_ptr_i      (rr_ptr_q),
    .grant_o       (grant),
    .grant_valid_o (grant_valid),
    .winner_o      (winner)
  );

  // Ready ignores kills so producers see a stable handshake.
  assign req_ready = ~slot_valid_q | grant;

  always_comb begin
    slot_valid_d = slot_valid_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slot_d[i] = slot_q[i];
      slot_d[i].control_bit_map = ctrl_clear(slot_q[i].control_bit_map, br_resolve_bit,
                                             resolve_ok);
      if (req_valid[i] && req_ready[i]) begin
        slot_d[i] = req_entry[i];
        slot_d[i].control_bit_map = ctrl_clear(req_entry[i].control_bit_map,
                                               br_resolve_bit, resolve_ok);
        slot_valid_d[i] = ~in_kill[i];
      end else if (grant[i] || slot_kill[i]) begin
        slot_valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
    end
  end

  // The bus already carries the post-resolve dependency map.
  always_comb begin
    cdb = slot_q[winner];
    cdb.control_bit_map = ctrl_clear(slot_q[winner].control_bit_map, br_resolve_bit,
                                     resolve_ok);
    cdb.valid = grant_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= '0;
      rr_ptr_q     <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_valid_q <= slot_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

endmodule
